// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the pipeline-state type used by the bridge
// master and slave front ends.
package ahb_pkg;

   localparam logic       HTRANS_IDLE   = 1'b0;
   localparam logic       HTRANS_NONSEQ = 1'b1;

   localparam logic [2:0] HSIZE_BYTE    = 3'd0;
   localparam logic [2:0] HSIZE_HALF    = 3'd1;
   localparam logic [2:0] HSIZE_WORD    = 3'd2;

   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   // {ap_valid, dp_valid}
   typedef enum logic [1:0] {
      PL_IDLE = 2'b00,
      PL_DATA = 2'b01,
      PL_ADDR = 2'b10,
      PL_PIPE = 2'b11
   } ahb_pipe_t;

endpackage

// File: rtl/ahb_master.sv
// AHB-Lite initiator: turns valid/rd0_wr1 requests into pipelined NONSEQ
// transfers and reports read data, write completion and error status.
module ahb_master
   import ahb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  i_clk_ahb,
   input  logic                  i_rst_ahb,
   input  logic                  i_valid,
   input  logic                  i_rd0_wr1,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [2:0]            i_size,
   output logic                  o_ready,
   output logic                  o_rd_valid,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_wr_done,
   output logic                  o_err,
   output logic                  o_htrans,
   output logic [ADDR_WIDTH-1:0] o_haddr,
   output logic                  o_hwrite,
   output logic [2:0]            o_hsize,
   output logic [DATA_WIDTH-1:0] o_hwdata,
   input  logic                  i_hready,
   input  logic                  i_hresp,
   input  logic [DATA_WIDTH-1:0] i_hrdata
);

   ahb_pipe_t             state_q;
   ahb_pipe_t             state_d;
   logic                  ap_valid;
   logic                  dp_valid;
   logic                  accept;
   logic                  ap_adv;
   logic                  dp_done;
   logic                  ap_next;
   logic                  dp_next;
   logic                  dp_write;
   logic [DATA_WIDTH-1:0] wr_shadow;

   always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
      if (i_rst_ahb) begin
         state_q <= PL_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      ap_valid = (state_q == PL_ADDR) || (state_q == PL_PIPE);
      dp_valid = (state_q == PL_DATA) || (state_q == PL_PIPE);
      o_ready  = !ap_valid || i_hready;
      accept   = i_valid && o_ready;
      ap_adv   = ap_valid && i_hready;
      dp_done  = dp_valid && i_hready;
      ap_next  = accept || (ap_valid && !ap_adv);
      // an advancing address phase refills the data phase as it drains
      dp_next  = ap_adv || (dp_valid && !dp_done);
      state_d  = PL_IDLE;
      case ({ap_next, dp_next})
         2'b00:   state_d = PL_IDLE;
         2'b01:   state_d = PL_DATA;
         2'b10:   state_d = PL_ADDR;
         default: state_d = PL_PIPE;
      endcase
   end

   always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
      if (i_rst_ahb) begin
         o_htrans   <= HTRANS_IDLE;
         o_haddr    <= '0;
         o_hwrite   <= 1'b0;
         o_hsize    <= '0;
         o_hwdata   <= '0;
         o_rd_valid <= 1'b0;
         o_rd_data  <= '0;
         o_wr_done  <= 1'b0;
         o_err      <= 1'b0;
         dp_write   <= 1'b0;
         wr_shadow  <= '0;
      end else begin
         o_rd_valid <= 1'b0;
         o_wr_done  <= 1'b0;
         o_err      <= 1'b0;

         if (accept) begin
            o_htrans  <= HTRANS_NONSEQ;
            o_haddr   <= i_addr;
            o_hwrite  <= i_rd0_wr1;
            o_hsize   <= i_size;
            wr_shadow <= i_wr_data;
         end else if (ap_adv) begin
            o_htrans  <= HTRANS_IDLE;
         end

         // shadow and hwrite still hold the advancing transfer here
         if (ap_adv) begin
            dp_write <= o_hwrite;
            if (o_hwrite) begin
               o_hwdata <= wr_shadow;
            end
         end

         if (dp_done) begin
            o_rd_valid <= !dp_write;
            o_wr_done  <= dp_write;
            o_err      <= (i_hresp == HRESP_ERROR);
            if (!dp_write) begin
               o_rd_data <= i_hrdata;
            end
         end
      end
   end

endmodule
